fb_stream_unpacker: RTL

- Downstream consumer of the rasterizer's 32-bit framebuffer AXI stream (ENABLE_FRAMEBUFFER_STREAM=1).
- Buffers incoming words, splits each word into two RGB565 pixels and emits one pixel per handshake to the display/scanout side.
- Generates start-of-frame and end-of-frame markers from a programmed frame size.
- Detects and reports mismatches between the input tlast and the pixel count.

---
 rtl/rix_fb_pkg.sv | 14 +
 rtl/fb_word_fifo.sv | 38 +++
 rtl/fb_stream_unpacker.sv | 97 +++++++++
 3 files changed

// File: rtl/rix_fb_pkg.sv
// rix_fb_pkg: shared framebuffer stream types, widths and unpacker FSM states
package rix_fb_pkg;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  localparam int FB_WORD_WIDTH = 32;
  localparam int PIXELS_PER_WORD = 2;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} fb_unpack_state_t;
  function automatic logic [15:0] swap_rb(input rgb565_t p);
    return {p.b, p.g, p.r};
  endfunction
endpackage

// File: rtl/fb_word_fifo.sv
// fb_word_fifo: first-word-fall-through synchronous FIFO with full/empty and registered occupancy
module fb_word_fifo #(
  parameter int DEPTH_LG = 4,
  parameter int WIDTH = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    din_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    dout_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LG:0]   count_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_LG];
  logic [DEPTH_LG-1:0] wr_q, rd_q;
  logic [DEPTH_LG:0] cnt_q;
  logic wr, rd;
  assign full_o = cnt_q == (DEPTH_LG+1)'(2**DEPTH_LG);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign wr = push_i && !full_o;
  assign rd = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + DEPTH_LG'(wr);
      rd_q <= rd_q + DEPTH_LG'(rd);
      cnt_q <= cnt_q + (DEPTH_LG+1)'(wr) - (DEPTH_LG+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/fb_stream_unpacker.sv
// fb_stream_unpacker: splits 32-bit framebuffer words into framed RGB565 pixels; FB_STREAM_UNPACKER_SWAP_RB_EN outputs BGR565
module fb_stream_unpacker
  import rix_fb_pkg::*;
#(
  parameter int FIFO_DEPTH_LG = 4,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic                           s_fb_axis_tvalid,
  output logic                           s_fb_axis_tready,
  input  logic                           s_fb_axis_tlast,
  input  logic [FB_WORD_WIDTH-1:0]       s_fb_axis_tdata,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] frame_pixels,
  output logic                           m_pix_axis_tvalid,
  input  logic                           m_pix_axis_tready,
  output logic [15:0]                    m_pix_axis_tdata,
  output logic                           m_pix_axis_tuser,
  output logic                           m_pix_axis_tlast,
  output logic                           frame_err,
  output logic [FRAME_CNT_WIDTH-1:0]     frames_done
);
  localparam int PW = FB_WORD_WIDTH / PIXELS_PER_WORD;
  localparam logic [FB_SIZE_IN_PIXEL_LG-1:0] ONE = 1;
  fb_unpack_state_t state_q, state_d;
  logic [FB_WORD_WIDTH:0] rd_word;
  logic [FIFO_DEPTH_LG:0] occ;
  logic empty, full, pop, load, fin, room, at_last, w_last, hs;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] fp_q, fp_d, cnt_q, cnt_d;
  logic vld_q, user_q, last_q, err_q, done_q;
  logic [15:0] pix_q, pix_d;
  logic [FRAME_CNT_WIDTH-1:0] frames_q;
  rgb565_t half;
  fb_word_fifo #(.DEPTH_LG(FIFO_DEPTH_LG), .WIDTH(FB_WORD_WIDTH+1)) u_fifo (
    .clk(aclk), .rst(reset), .push_i(s_fb_axis_tvalid),
    .din_i({s_fb_axis_tlast, s_fb_axis_tdata}), .pop_i(pop),
    .dout_o(rd_word), .full_o(full), .empty_o(empty), .count_o(occ)
  );
  assign s_fb_axis_tready = !full;
  always_ff @(posedge aclk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? ((occ != '0 && frame_pixels != '0) ? LOW : IDLE)
            : fin ? IDLE
            : load ? (state_q == LOW ? HIGH : LOW)
            : state_q;
  // An early input tlast ends the frame on the high half; reaching the count ends it anywhere
  always_comb begin
    room = !vld_q || m_pix_axis_tready;
    hs = vld_q && m_pix_axis_tready;
    at_last = cnt_q == fp_q - ONE;
    w_last = rd_word[FB_WORD_WIDTH];
    half = state_q == HIGH ? rd_word[FB_WORD_WIDTH-1:PW] : rd_word[PW-1:0];
    load = state_q != IDLE && !empty && room;
    fin = load && (at_last || (state_q == HIGH && w_last));
    pop = load && (state_q == HIGH || at_last);
    cnt_d = fin ? '0 : load ? cnt_q + ONE : cnt_q;
    fp_d = state_q == IDLE ? frame_pixels : fp_q;
  end
`ifdef FB_STREAM_UNPACKER_SWAP_RB_EN
  assign pix_d = swap_rb(half);
`else
  assign pix_d = half;
`endif
  always_ff @(posedge aclk or posedge reset)
    if (reset) begin
      fp_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      pix_q <= '0;
      user_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      frames_q <= '0;
    end else begin
      fp_q <= fp_d;
      cnt_q <= cnt_d;
      if (load) begin
        vld_q <= 1'b1;
        pix_q <= pix_d;
        user_q <= cnt_q == '0;
        last_q <= fin;
        err_q <= fin && !(at_last && w_last);
        done_q <= at_last;
      end else if (m_pix_axis_tready) vld_q <= 1'b0;
      if (hs && last_q && done_q) frames_q <= frames_q + FRAME_CNT_WIDTH'(1);
    end
  assign m_pix_axis_tvalid = vld_q;
  assign m_pix_axis_tdata = pix_q;
  assign m_pix_axis_tuser = user_q;
  assign m_pix_axis_tlast = last_q;
  assign frame_err = hs && err_q;
  assign frames_done = frames_q;
endmodule
